// File: rtl/sram_1rw_param_model.sv
// sram_1rw_param_model: behavioural single-port SRAM with lane write mask and 1- or 2-stage read pipeline
module sram_1rw_param_model #(
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 64,
   parameter int ADDR_WIDTH   = 6,
   parameter int WMASK_GRAN   = 8,
   parameter int MASK_WIDTH   = DATA_WIDTH / WMASK_GRAN,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] RW0_addr,
   input  logic                  RW0_en,
   input  logic                  RW0_wmode,
   input  logic [MASK_WIDTH-1:0] RW0_wmask,
   input  logic [DATA_WIDTH-1:0] RW0_wdata,
   output logic [DATA_WIDTH-1:0] RW0_rdata,
   output logic                  RW0_rvalid,
   output logic                  RW0_oob
);
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
   if (DATA_WIDTH % WMASK_GRAN != 0) begin : g_bad_gran
      $error("sram_1rw_param_model: WMASK_GRAN must divide DATA_WIDTH");
   end
   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
      $error("sram_1rw_param_model: READ_LATENCY must be 1 or 2");
   end
   if ((64'(1) << ADDR_WIDTH) < 64'(DEPTH)) begin : g_bad_addr
      $error("sram_1rw_param_model: ADDR_WIDTH too small for DEPTH");
   end
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] s1_data;
   logic                  s1_valid;
   logic                  in_range;
   logic                  rd_issue;
   logic                  wr_issue;
   assign in_range = {1'b0, RW0_addr} < DEPTH_L;
   assign rd_issue = !reset && RW0_en && !RW0_wmode;
   assign wr_issue = !reset && RW0_en && RW0_wmode && in_range;
   // array update: only enabled lanes of an in-range write change; contents survive reset
   always_ff @(posedge clock)
      if (wr_issue)
         for (int i = 0; i < MASK_WIDTH; i++)
            if (RW0_wmask[i])
               mem[RW0_addr][i*WMASK_GRAN +: WMASK_GRAN] <= RW0_wdata[i*WMASK_GRAN +: WMASK_GRAN];
   // first read stage: capture the word at the issue edge, zero for out-of-range, hold otherwise
   always_ff @(posedge clock)
      if (reset) begin
         s1_data  <= '0;
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= rd_issue;
         if (rd_issue) s1_data <= in_range ? mem[RW0_addr] : '0;
      end
   // out-of-range flag follows any enabled access by one cycle
   always_ff @(posedge clock)
      if (reset) RW0_oob <= 1'b0;
      else RW0_oob <= RW0_en && !in_range;
   if (READ_LATENCY == 2) begin : g_lat2
      // extra output register; data only moves when a read completes so it holds between reads
      always_ff @(posedge clock)
         if (reset) begin
            RW0_rdata  <= '0;
            RW0_rvalid <= 1'b0;
         end else begin
            RW0_rvalid <= s1_valid;
            if (s1_valid) RW0_rdata <= s1_data;
         end
   end else begin : g_lat1
      assign RW0_rdata  = s1_data;
      assign RW0_rvalid = s1_valid;
   end
endmodule

// File: tb/tb_sram_1rw_param_model.sv
// tb_sram_1rw_param_model: scoreboard bench driving a default SRAM and a DEPTH=48/latency-2 SRAM in parallel
module tb_sram_1rw_param_model;
   typedef struct { logic [31:0] data; int due; } exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        wm = 1'b0;
   logic [5:0]  addr = '0;
   logic [3:0]  mask = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata0, rdata1;
   logic        rvalid0, rvalid1, oob0, oob1;
   int          n_vec = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          depth [2] = '{64, 48};
   int          lat [2] = '{1, 2};
   logic [31:0] mdl [2][64];
   logic [31:0] hold [2] = '{32'h0, 32'h0};
   exp_t        q0 [$];
   exp_t        q1 [$];
   bit          rst_at [int];
   bit          oob_at0 [int];
   bit          oob_at1 [int];

   always #5 clk = ~clk;

   sram_1rw_param_model dut0 (
      .clock(clk), .reset(rst), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wm),
      .RW0_wmask(mask), .RW0_wdata(wdata), .RW0_rdata(rdata0), .RW0_rvalid(rvalid0), .RW0_oob(oob0)
   );
   sram_1rw_param_model #(.DEPTH(48), .READ_LATENCY(2)) dut1 (
      .clock(clk), .reset(rst), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wm),
      .RW0_wmask(mask), .RW0_wdata(wdata), .RW0_rdata(rdata1), .RW0_rvalid(rvalid1), .RW0_oob(oob1)
   );

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic chk(input int k, input logic [31:0] rd, input logic rv, input logic ob);
      exp_t f;
      bit   due;
      bit   ob_exp;
      if (rst_at.exists(cyc)) hold[k] = 32'h0;
      due = k == 0 ? (q0.size() > 0 && q0[0].due == cyc) : (q1.size() > 0 && q1[0].due == cyc);
      ob_exp = k == 0 ? oob_at0.exists(cyc) : oob_at1.exists(cyc);
      if (due) begin
         if (k == 0) f = q0.pop_front();
         else f = q1.pop_front();
         hold[k] = f.data;
      end
      cmp($sformatf("rvalid%0d", k), 32'(rv), 32'(due));
      cmp($sformatf("rdata%0d", k), rd, hold[k]);
      cmp($sformatf("oob%0d", k), 32'(ob), 32'(ob_exp));
   endtask

   // monitor: sample just after each rising edge and check both DUTs against the scoreboard
   always @(posedge clk) begin
      #1;
      cyc++;
      chk(0, rdata0, rvalid0, oob0);
      chk(1, rdata1, rvalid1, oob1);
   end

   task automatic drive(input bit r, input bit e, input bit w, input logic [5:0] a,
                        input logic [3:0] m, input logic [31:0] d);
      int edge_n;
      @(negedge clk);
      rst = r; en = e; wm = w; addr = a; mask = m; wdata = d;
      edge_n = cyc + 1;
      if (r) begin
         rst_at[edge_n] = 1'b1;
         q0.delete();
         q1.delete();
      end else if (e) begin
         for (int k = 0; k < 2; k++) begin
            if (int'(a) >= depth[k]) begin
               if (k == 0) oob_at0[edge_n] = 1'b1;
               else oob_at1[edge_n] = 1'b1;
            end
            if (w && int'(a) < depth[k]) begin
               for (int l = 0; l < 4; l++)
                  if (m[l]) mdl[k][a][l*8 +: 8] = d[l*8 +: 8];
            end else if (!w) begin
               exp_t x;
               x.data = int'(a) < depth[k] ? mdl[k][a] : 32'h0;
               x.due = edge_n + lat[k] - 1;
               if (k == 0) q0.push_back(x);
               else q1.push_back(x);
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 6'd0, 4'h0, 32'h0);
   endtask

   task automatic wr(input logic [5:0] a, input logic [3:0] m, input logic [31:0] d);
      drive(1'b0, 1'b1, 1'b1, a, m, d);
   endtask

   task automatic rd(input logic [5:0] a);
      drive(1'b0, 1'b1, 1'b0, a, 4'h0, $urandom);
   endtask

   initial begin
      rst_at[1] = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 6'd0, 4'h0, 32'h0);
      drive(1'b1, 1'b1, 1'b1, 6'd5, 4'hF, 32'hBAD0BAD0);
      for (int a = 0; a < 64; a++) wr(6'(a), 4'hF, $urandom);
      wr(6'd5, 4'hF, 32'hDEADBEEF);
      rd(6'd5);
      idle(3);
      wr(6'd3, 4'hF, 32'h11223344);
      wr(6'd3, 4'b0101, 32'hAABBCCDD);
      rd(6'd3);
      idle(2);
      wr(6'd0, 4'hF, 32'hA0);
      wr(6'd1, 4'hF, 32'hA1);
      wr(6'd2, 4'hF, 32'hA2);
      rd(6'd0);
      rd(6'd1);
      rd(6'd2);
      rd(6'd1);
      wr(6'd1, 4'hF, 32'hFF);
      rd(6'd1);
      idle(3);
      wr(6'd50, 4'hF, 32'h1234);
      rd(6'd50);
      rd(6'd47);
      idle(2);
      rd(6'd5);
      drive(1'b1, 1'b0, 1'b0, 6'd0, 4'h0, 32'h0);
      idle(2);
      rd(6'd5);
      idle(3);
      drive(1'b0, 1'b0, 1'b1, 6'd5, 4'hF, 32'h0);
      idle(2);
      rd(6'd5);
      wr(6'd7, 4'h0, 32'h55555555);
      rd(6'd7);
      idle(3);
      for (int i = 0; i < 3000; i++)
         drive(($urandom % 60) == 0, ($urandom % 4) != 0, $urandom % 2,
               6'($urandom % 64), 4'($urandom), $urandom);
      idle(4);
      cmp("drain0", q0.size(), 32'h0);
      cmp("drain1", q1.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
